ifu_fetch: RTL and testbench

- Instruction fetch unit; the producer side of the IFU→IDU valid/ready handshake.
- Holds the architectural PC and fetches one 32-bit instruction per PC over an AXI4-Lite read channel.
- Presents {inst, pc} to the decoder, then waits for the next PC from the writeback stage.
- Single-issue multicycle: at most one instruction in flight between fetch and writeback.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_perf_cnt.sv | 50 +++++
 rtl/ifu_fetch.sv | 179 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// AXI read-response codes, the default reset PC and an alignment helper.
package ifu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    FETCH_AR = 3'd0,
    FETCH_R  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_NPC = 3'd3,
    HALT     = 3'd4
  } ifu_state_e;

  // Instructions are 32-bit words, so any PC with low bits set is unusable.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Three free-running 32-bit event counters (completed fetches, busy cycles,
// stall cycles). Generic enough to be reused by the decode and execute stages;
// simulation harnesses read them through the getters.
module ifu_perf_cnt (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fetch_done_i,
  input  logic fetch_busy_i,
  input  logic stall_i
);

  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] fetch_cycles_q, fetch_cycles_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Increment each counter on its enable; wrap naturally at 2^32.
  always_comb begin
    fetch_count_d  = fetch_count_q  + {31'b0, fetch_done_i};
    fetch_cycles_d = fetch_cycles_q + {31'b0, fetch_busy_i};
    stall_cycles_d = stall_cycles_q + {31'b0, stall_i};
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_count_q  <= '0;
      fetch_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      fetch_cycles_q <= fetch_cycles_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

`ifndef SYNTHESIS
  function int unsigned perf_get_fetch_count();
    return fetch_count_q;
  endfunction

  function int unsigned perf_get_fetch_cycles();
    return fetch_cycles_q;
  endfunction

  function int unsigned perf_get_stall_cycles();
    return stall_cycles_q;
  endfunction
`endif

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, reads one instruction per PC over
// AXI4-Lite, hands {inst, pc} to decode, then waits for the next PC from
// writeback. Single-issue: at most one instruction in flight.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH_AR | arvalid high with araddr=pc, waiting for arready
//   FETCH_R  | rready high, waiting for the read beat
//   ISSUE    | ifu_valid high, inst/pc held until decode accepts
//   WAIT_NPC | waiting for writeback to deliver the next PC
//   HALT     | bus error or protocol violation; only reset leaves
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] ifu_to_idu_pc,
  output logic              ifu_valid,
  input  logic              ifu_ready,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic              fetch_err,
  output logic [2:0]        state_out
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              err_q, err_d;

  logic              redirect;
  logic              early_npc;
  logic [ADDR_W-1:0] next_pc;
  logic              fetch_done;

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    ipc_d        = ipc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    err_d        = err_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ifu_valid    = 1'b0;
    redirect     = 1'b0;
    fetch_done   = 1'b0;
    next_pc      = pend_valid_q ? pend_pc_q : npc;

    case (state_q)
      FETCH_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = FETCH_R;
      end
      FETCH_R: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rresp == RESP_OKAY) begin
            inst_d     = rdata;
            ipc_d      = pc_q;
            fetch_done = 1'b1;
            state_d    = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        ifu_valid = 1'b1;
        if (ifu_ready) begin
          state_d  = WAIT_NPC;
          // A PC already known at handshake time skips the idle wait.
          redirect = 1'b1;
        end
      end
      WAIT_NPC: redirect = 1'b1;
      HALT: ;
      default: begin
        err_d   = 1'b1;
        state_d = HALT;
      end
    endcase

    // Start the next fetch from the pending slot first, else from writeback.
    if (redirect && (pend_valid_q || npc_valid)) begin
      pend_valid_d = 1'b0;
      if (!is_word_aligned(next_pc[1:0])) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = next_pc;
        state_d = FETCH_AR;
      end
      // Slot drained this cycle, so a simultaneous writeback PC refills it.
      if (pend_valid_q && npc_valid) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = npc;
      end
    end

    // Next PC arriving while the current instruction is still in flight.
    if (early_npc) begin
      if (pend_valid_q) begin
        err_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_pc_d    = npc;
      end
    end
  end

  assign early_npc = npc_valid &&
                     ((state_q == FETCH_AR) || (state_q == FETCH_R) ||
                      ((state_q == ISSUE) && !ifu_ready));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FETCH_AR;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      ipc_q        <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      ipc_q        <= ipc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      err_q        <= err_d;
    end
  end

  assign araddr        = pc_q;
  assign inst          = inst_q;
  assign ifu_to_idu_pc = ipc_q;
  assign fetch_err     = err_q;
  assign state_out     = state_q;

  ifu_perf_cnt u_perf (
    .clk_i        (clock),
    .rst_i        (reset),
    .fetch_done_i (fetch_done),
    .fetch_busy_i ((state_q == FETCH_AR) || (state_q == FETCH_R)),
    .stall_i      ((state_q == ISSUE) && !ifu_ready)
  );

`ifndef SYNTHESIS
  a_ar_hold: assert property (@(posedge clock) disable iff (reset)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)))
    else $error("ifu_fetch: arvalid/araddr changed before arready");

  a_issue_hold: assert property (@(posedge clock) disable iff (reset)
    (ifu_valid && !ifu_ready) |=>
      (ifu_valid && $stable(inst) && $stable(ifu_to_idu_pc)))
    else $error("ifu_fetch: inst/pc changed before ifu_ready");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: read beats push {inst, pc} into a scoreboard,
// the decode handshake pops and compares them.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] ifu_to_idu_pc;
  logic        ifu_valid;
  logic        ifu_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_err;
  logic [2:0]  state_out;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  ifu_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .ifu_to_idu_pc(ifu_to_idu_pc),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .npc_valid(npc_valid), .npc(npc),
    .fetch_err(fetch_err), .state_out(state_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_state", 32'(state_out), 32'(FETCH_AR));
    chk("rst_araddr", araddr, RST_PC);
    chk("rst_ctl", {28'b0, arvalid, rready, ifu_valid, fetch_err}, 32'h8);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", ifu_to_idu_pc, RST_PC);
    chk("rst_fetch_count", dut.u_perf.fetch_count_q, 32'd0);
    chk("rst_fetch_cycles", dut.u_perf.fetch_cycles_q, 32'd0);
    chk("rst_stall_cycles", dut.u_perf.stall_cycles_q, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; arready = 1'b0; rvalid = 1'b0; npc_valid = 1'b0; ifu_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    sb.delete();
  endtask

  // Starts in FETCH_AR; ends one cycle after the read beat.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int ar_wait, input int r_wait);
    chk("ar_state", 32'(state_out), 32'(FETCH_AR));
    chk("ar_addr", araddr, addr);
    chk("ar_ctl", {29'b0, arvalid, rready, ifu_valid}, 32'h4);
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      step();
      chk("ar_hold_valid", {31'b0, arvalid}, 32'h1);
      chk("ar_hold_addr", araddr, addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r_ctl", {29'b0, arvalid, rready, ifu_valid}, 32'h2);
    for (int i = 0; i < r_wait; i++) begin
      rvalid = 1'b0;
      step();
      chk("r_hold_state", 32'(state_out), 32'(FETCH_R));
    end
    rvalid = 1'b1; rdata = data; rresp = resp;
    if (resp == RESP_OKAY) sb.push_back({data, addr});
    step();
    rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
  endtask

  // Starts in ISSUE; holds ifu_ready low rw cycles, then completes the handshake.
  task automatic do_issue(input int rw, input ifu_state_e after);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    exp = sb[0];
    for (int i = 0; i < rw; i++) begin
      ifu_ready = 1'b0;
      chk("stall_valid", {31'b0, ifu_valid}, 32'h1);
      chk("stall_inst", inst, exp[63:32]);
      chk("stall_pc", ifu_to_idu_pc, exp[31:0]);
      step();
    end
    ifu_ready = 1'b1;
    exp = sb.pop_front();
    chk("hs_valid", {31'b0, ifu_valid}, 32'h1);
    chk("hs_inst", inst, exp[63:32]);
    chk("hs_pc", ifu_to_idu_pc, exp[31:0]);
    step();
    ifu_ready = 1'b0;
    chk("hs_next_state", 32'(state_out), 32'(after));
  endtask

  // Starts in WAIT_NPC.
  task automatic give_npc(input logic [31:0] v);
    npc_valid = 1'b1; npc = v;
    step();
    npc_valid = 1'b0; npc = '0;
    chk("npc_state", 32'(state_out), 32'(FETCH_AR));
    chk("npc_araddr", araddr, v);
    chk("npc_arvalid", {31'b0, arvalid}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; arready = 1'b0; rdata = '0; rresp = RESP_OKAY; rvalid = 1'b0;
    ifu_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    step(); step(); step();
    reset = 1'b0;
    check_reset();

    // zero-wait fetch, ifu_valid in the third cycle
    do_fetch(RST_PC, 32'h0000_0413, RESP_OKAY, 0, 0);
    chk("t1_state", 32'(state_out), 32'(ISSUE));
    chk("t1_fetch_count", dut.u_perf.fetch_count_q, 32'd1);
    chk("t1_fetch_cycles", dut.u_perf.fetch_cycles_q, 32'd2);
    do_issue(0, WAIT_NPC);
    give_npc(32'h8000_0004);

    // slow slave and stalled decoder
    do_fetch(32'h8000_0004, 32'h0010_0093, RESP_OKAY, 4, 3);
    chk("t2_fetch_cycles", dut.u_perf.fetch_cycles_q, 32'd11);
    chk("t2_fetch_count", dut.u_perf.fetch_count_q, 32'd2);
    do_issue(5, WAIT_NPC);
    chk("t2_stall_cycles", dut.u_perf.stall_cycles_q, 32'd5);
    give_npc(32'h8000_0008);

    // early npc during FETCH_R goes straight to the next fetch
    arready = 1'b1; step(); arready = 1'b0;
    chk("t3_state_r", 32'(state_out), 32'(FETCH_R));
    npc_valid = 1'b1; npc = 32'h8000_0010;
    step();
    npc_valid = 1'b0; npc = '0;
    chk("t3_err_clear", {31'b0, fetch_err}, 32'h0);
    rvalid = 1'b1; rdata = 32'h0020_8113; sb.push_back({32'h0020_8113, 32'h8000_0008});
    step();
    rvalid = 1'b0; rdata = '0;
    chk("t3_araddr_held", araddr, 32'h8000_0008);
    do_issue(0, FETCH_AR);
    chk("t3_araddr_pend", araddr, 32'h8000_0010);
    chk("t3_arvalid", {31'b0, arvalid}, 32'h1);
    do_fetch(32'h8000_0010, 32'h0030_8193, RESP_OKAY, 0, 1);
    do_issue(1, WAIT_NPC);

    // misaligned npc halts without a bus request
    npc_valid = 1'b1; npc = 32'h8000_0022;
    step();
    npc_valid = 1'b0; npc = '0;
    chk("mis_state", 32'(state_out), 32'(HALT));
    chk("mis_err", {31'b0, fetch_err}, 32'h1);
    step();
    chk("mis_no_ar", {29'b0, arvalid, rready, ifu_valid}, 32'h0);

    // error response: sticky error, halted for 20 cycles, reset recovers
    do_reset();
    check_reset();
    do_fetch(RST_PC, 32'hdead_beef, RESP_SLVERR, 0, 0);
    chk("err_state", 32'(state_out), 32'(HALT));
    chk("err_flag", {31'b0, fetch_err}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      npc_valid = (i == 5);
      npc = 32'h8000_0040;
      step();
      chk("halt_ctl", {29'b0, arvalid, rready, ifu_valid}, 32'h0);
      chk("halt_state", 32'(state_out), 32'(HALT));
    end
    npc_valid = 1'b0; npc = '0;
    chk("err_fetch_count", dut.u_perf.fetch_count_q, 32'd0);
    do_reset();
    check_reset();

    // pending overflow: second early npc dropped, error raised, FSM continues
    arready = 1'b1; step(); arready = 1'b0;
    npc_valid = 1'b1; npc = 32'h8000_0100;
    step();
    chk("ovf_first_ok", {31'b0, fetch_err}, 32'h0);
    npc = 32'h8000_0200;
    step();
    npc_valid = 1'b0; npc = '0;
    chk("ovf_err", {31'b0, fetch_err}, 32'h1);
    chk("ovf_state", 32'(state_out), 32'(FETCH_R));
    rvalid = 1'b1; rdata = 32'h0040_0213; sb.push_back({32'h0040_0213, RST_PC});
    step();
    rvalid = 1'b0; rdata = '0;
    do_issue(0, FETCH_AR);
    chk("ovf_araddr", araddr, 32'h8000_0100);

    // reset in FETCH_R with the beat arriving one cycle later
    arready = 1'b1; step(); arready = 1'b0;
    chk("rr_state_r", 32'(state_out), 32'(FETCH_R));
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    rvalid = 1'b1; rdata = 32'hbad0_0bad; rresp = RESP_OKAY;
    check_reset();
    step();
    rvalid = 1'b0; rdata = '0;
    chk("rr_state_ar", 32'(state_out), 32'(FETCH_AR));
    chk("rr_count", dut.u_perf.fetch_count_q, 32'd0);
    do_fetch(RST_PC, 32'h0050_0293, RESP_OKAY, 0, 0);
    do_issue(0, WAIT_NPC);
    chk("rr_fetch_count", dut.u_perf.fetch_count_q, 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
